// File: rtl/seq_tx_moore.sv
// rtl/seq_tx_moore.sv - serial pattern transmitter with a consecutive-ones reference model
// Emits a loaded pattern MSB-first with optional zero gaps between repetitions; exp_detect models a RUN_LEN-ones Moore detector.
module seq_tx_moore #(
  parameter int WIDTH      = 8,
  parameter int GAP_CYCLES = 2,
  parameter int RUN_LEN    = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] pattern,
  input  logic [4:0]       nbits,
  input  logic [3:0]       reps,
  output logic             data_out,
  output logic             valid,
  output logic             busy,
  output logic             done,
  output logic             exp_detect
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LOAD = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam int OW = $clog2(RUN_LEN + 1);
  localparam logic [OW-1:0] RUN_MAX = OW'(RUN_LEN);
  localparam logic [4:0] WIDTH_5 = 5'(WIDTH);

  logic [1:0]       state;
  logic [WIDTH-1:0] shift_reg;
  logic [WIDTH-1:0] pat_hold;
  logic [4:0]       bit_cnt;
  logic [4:0]       len_hold;
  logic [3:0]       rep_cnt;
  logic [GW-1:0]    gap_cnt;
  logic [OW-1:0]    ones_cnt;
  logic [OW-1:0]    ones_nxt;
  logic             exp_q;
  logic [4:0]       nbits_norm;
  logic [3:0]       reps_norm;

  always_comb begin
    nbits_norm = nbits;
    if (nbits == 5'd0 || nbits > WIDTH_5) nbits_norm = WIDTH_5;
    reps_norm = (reps == 4'd0) ? 4'd1 : reps;
  end

  // Outputs decode state and registers only, so no input reaches an output combinationally.
  assign data_out   = (state == S_SHIFT) & shift_reg[WIDTH-1];
  assign valid      = (state == S_SHIFT);
  assign busy       = (state != S_IDLE);
  assign done       = (state == S_DONE);
  assign exp_detect = exp_q;

  always_comb begin
    ones_nxt = '0;
    if (data_out) ones_nxt = (ones_cnt == RUN_MAX) ? ones_cnt : ones_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ones_cnt <= '0;
      exp_q    <= 1'b0;
    end else begin
      ones_cnt <= ones_nxt;
      exp_q    <= (ones_nxt == RUN_MAX);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      shift_reg <= '0;
      pat_hold  <= '0;
      bit_cnt   <= '0;
      len_hold  <= '0;
      rep_cnt   <= '0;
      gap_cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            shift_reg <= pattern;
            pat_hold  <= pattern;
            bit_cnt   <= nbits_norm;
            len_hold  <= nbits_norm;
            rep_cnt   <= reps_norm;
            state     <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (bit_cnt == 5'd1 && rep_cnt > 4'd1) begin
            rep_cnt   <= rep_cnt - 4'd1;
            shift_reg <= pat_hold;
            bit_cnt   <= len_hold;
            if (GAP_CYCLES == 0) begin
              state <= S_SHIFT;
            end else begin
              gap_cnt <= GAP_LOAD;
              state   <= S_GAP;
            end
          end else begin
            shift_reg <= {shift_reg[WIDTH-2:0], 1'b0};
            bit_cnt   <= bit_cnt - 5'd1;
            if (bit_cnt == 5'd1) state <= S_DONE;
          end
        end
        S_GAP: begin
          if (gap_cnt == '0) state <= S_SHIFT;
          else gap_cnt <= gap_cnt - 1'b1;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_tx_moore.sv
// tb/tb_seq_tx_moore.sv - scoreboard bench for seq_tx_moore
// Stimulus pushes per-cycle expectations; a negedge monitor pops and compares while busy.
module tb_seq_tx_moore;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] pattern;
  logic [4:0] nbits;
  logic [3:0] reps;
  logic       data_out, valid, busy, done, exp_detect;

  seq_tx_moore #(.WIDTH(8), .GAP_CYCLES(2), .RUN_LEN(3)) dut (
    .clk(clk), .reset(reset), .start(start), .pattern(pattern), .nbits(nbits), .reps(reps),
    .data_out(data_out), .valid(valid), .busy(busy), .done(done), .exp_detect(exp_detect)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [4:0] v;
  } rec_t;

  rec_t  exp_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  bit    mon_en = 1'b0;
  string cur_name = "none";

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Independent 3-ones detector fed by the serial line.
  logic [1:0] det_cnt;
  always @(posedge clk or negedge reset) begin
    if (!reset) det_cnt <= 2'd0;
    else if (!data_out) det_cnt <= 2'd0;
    else if (det_cnt != 2'd3) det_cnt <= det_cnt + 2'd1;
  end

  always @(negedge clk) begin : monitor
    rec_t r;
    if (reset && mon_en && busy) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_busy in %s actual=busy required=idle", cur_name);
      end else begin
        r = exp_q.pop_front();
        chk($sformatf("%s_c%0d {d,v,b,done,exp}", cur_name, r.cyc),
            {27'd0, data_out, valid, busy, done, exp_detect}, {27'd0, r.v});
      end
    end
    if (reset) chk("exp_vs_detector", {31'd0, exp_detect}, {31'd0, (det_cnt == 2'd3)});
  end

  task automatic push_hand(input int n, input logic [31:0] d, input logic [31:0] v, input logic [31:0] x);
    rec_t r;
    for (int c = 1; c <= n; c++) begin
      r.cyc = c;
      r.v   = {d[n-c], v[n-c], 1'b1, (c == n), x[n-c]};
      exp_q.push_back(r);
    end
  endtask

  task automatic push_model(input logic [7:0] p, input logic [4:0] nb, input logic [3:0] rp);
    int   n, rr, cnt;
    logic dq[$];
    logic vq[$];
    rec_t r;
    n  = (nb == 0 || nb > 8) ? 8 : int'(nb);
    rr = (rp == 0) ? 1 : int'(rp);
    for (int i = 0; i < rr; i++) begin
      for (int b = 0; b < n; b++) begin
        dq.push_back(p[7-b]);
        vq.push_back(1'b1);
      end
      if (i < rr - 1) begin
        for (int g = 0; g < 2; g++) begin
          dq.push_back(1'b0);
          vq.push_back(1'b0);
        end
      end
    end
    dq.push_back(1'b0);
    vq.push_back(1'b0);
    cnt = 0;
    for (int c = 0; c < dq.size(); c++) begin
      r.cyc = c + 1;
      r.v   = {dq[c], vq[c], 1'b1, (c == dq.size() - 1), (cnt == 3)};
      exp_q.push_back(r);
      cnt = dq[c] ? ((cnt == 3) ? 3 : cnt + 1) : 0;
    end
  endtask

  task automatic fire(input logic [7:0] p, input logic [4:0] nb, input logic [3:0] rp, input bit scramble);
    bit drained;
    @(negedge clk);
    pattern = p; nbits = nb; reps = rp; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (scramble) begin
      pattern = ~p; nbits = 5'd3; reps = 4'd5;
    end
    drained = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (exp_q.size() == 0) begin
        drained = 1'b1;
        break;
      end
      @(negedge clk);
      #1;
    end
    if (!drained) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_timeout actual=%0d_pending required=0", cur_name, exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
    chk({cur_name, "_idle_after {b,v,d}"}, {29'd0, busy, valid, data_out}, 32'd0);
  endtask

  initial begin
    #3_000_000;
    n_bad++;
    $display("FAIL watchdog actual=running required=finished");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int         dones, iters;
    bit         prev;
    logic [7:0] rp8;
    logic [4:0] rnb;
    logic [3:0] rrp;

    reset = 1'b0; start = 1'b0; pattern = 8'h00; nbits = 5'd0; reps = 4'd0;
    repeat (2) @(negedge clk);
    chk("reset_state", {27'd0, data_out, valid, busy, done, exp_detect}, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("idle_after_release", {30'd0, busy, valid}, 32'd0);

    // Asynchronous reset in the middle of a run of ones.
    cur_name = "reset_mid";
    @(negedge clk);
    pattern = 8'hFF; nbits = 5'd8; reps = 4'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_shift {d,v,b,exp}", {28'd0, data_out, valid, busy, exp_detect}, 32'hF);
    #2 reset = 1'b0;
    #1 chk("async_reset", {27'd0, data_out, valid, busy, done, exp_detect}, 32'd0);
    @(negedge clk);
    chk("reset_held", {27'd0, data_out, valid, busy, done, exp_detect}, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("post_reset_idle", {28'd0, busy, valid, data_out, done}, 32'd0);
    mon_en = 1'b1;

    cur_name = "t_e0";
    push_hand(9, 32'b111000000, 32'b111111110, 32'b000100000);
    fire(8'b1110_0000, 5'd8, 4'd1, 1'b0);

    cur_name = "t_ff_n5_r2";
    push_hand(13, 32'b1111100111110, 32'b1111100111110, 32'b0001110000111);
    fire(8'hFF, 5'd5, 4'd2, 1'b0);

    cur_name = "t_a5_zero";
    push_hand(9, 32'b101001010, 32'b111111110, 32'b000000000);
    fire(8'hA5, 5'd0, 4'd0, 1'b0);

    cur_name = "t_nbits_big_hold";
    push_hand(9, 32'b011101110, 32'b111111110, 32'b000010001);
    fire(8'b0111_0111, 5'd20, 4'd1, 1'b1);

    cur_name = "t_n1_r3";
    push_hand(8, 32'b10010010, 32'b10010010, 32'b00000000);
    fire(8'h80, 5'd1, 4'd3, 1'b0);

    // start held high: one transfer per IDLE entry, single idle cycle between them.
    cur_name = "t_held";
    for (int k = 0; k < 3; k++) push_hand(5, 32'b10110, 32'b11110, 32'b00000);
    @(negedge clk);
    pattern = 8'b1011_0000; nbits = 5'd4; reps = 4'd1; start = 1'b1;
    dones = 0; prev = 1'b0; iters = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      #1;
      iters++;
      if (prev) chk("held_idle_gap", {31'd0, busy}, 32'd0);
      prev = done;
      if (done) dones++;
      if (dones == 3) break;
    end
    start = 1'b0;
    chk("held_cycles", iters, 32'd17);
    chk("held_dones", dones, 32'd3);
    @(negedge clk);
    chk("held_end_idle", {31'd0, busy}, 32'd0);
    @(negedge clk);
    chk("held_no_restart", {31'd0, busy}, 32'd0);

    cur_name = "t_random";
    for (int k = 0; k < 1000; k++) begin
      rp8 = 8'($urandom);
      rnb = 5'($urandom_range(0, 10));
      rrp = 4'($urandom_range(0, 2));
      push_model(rp8, rnb, rrp);
      fire(rp8, rnb, rrp, 1'($urandom_range(0, 1)));
    end

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
